// File: rtl/seq_mem_d1_2p_if.sv
// Load/store port bundle for seq_mem_d1_2p: an independent read channel and write channel.
// The client drives through master; the memory sits behind slave.
interface seq_mem_d1_2p_if #(
  parameter int WIDTH    = 32,
  parameter int IDX_SIZE = 4
);
  logic [IDX_SIZE-1:0] read_addr0;
  logic                read_en;
  logic [WIDTH-1:0]    out;
  logic                read_done;
  logic [IDX_SIZE-1:0] write_addr0;
  logic [WIDTH-1:0]    in;
  logic                write_en;
  logic                write_done;

  modport master (
    output read_addr0, read_en, write_addr0, in, write_en,
    input  out, read_done, write_done
  );

  modport slave (
    input  read_addr0, read_en, write_addr0, in, write_en,
    output out, read_done, write_done
  );
endinterface

// File: rtl/seq_mem_d1_2p.sv
// Simple dual-port sequential memory: one read and one write per cycle, pipelined read of
// READ_LATENCY cycles, selectable read-during-write behaviour on address collision.
module seq_mem_d1_2p #(
  parameter int WIDTH        = 32,
  parameter int SIZE         = 16,
  parameter int IDX_SIZE     = 4,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_FIRST  = 1,
  parameter int OOB_ERROR    = 1
) (
  input logic            clk,
  input logic            reset,
  seq_mem_d1_2p_if.slave bus
);

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("seq_mem_d1_2p: READ_LATENCY=%0d outside 1..4", READ_LATENCY);
  end
  if (SIZE > (1 << IDX_SIZE)) begin : g_bad_size
    $error("seq_mem_d1_2p: SIZE=%0d does not fit IDX_SIZE=%0d", SIZE, IDX_SIZE);
  end

  logic [WIDTH-1:0] mem [SIZE];
  logic             rd_in_range;
  logic             wr_in_range;
  logic             same_addr;
  logic [WIDTH-1:0] rd_word;
  logic             write_done_reg;

  if (SIZE >= (1 << IDX_SIZE)) begin : g_full_range
    assign rd_in_range = 1'b1;
    assign wr_in_range = 1'b1;
  end else begin : g_part_range
    assign rd_in_range = bus.read_addr0 < IDX_SIZE'(SIZE);
    assign wr_in_range = bus.write_addr0 < IDX_SIZE'(SIZE);
  end

  assign same_addr = bus.write_en && wr_in_range && (bus.write_addr0 == bus.read_addr0);

  // Stage-0 word: out-of-range reads yield zero; a colliding write is bypassed when write-first.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      if (WRITE_FIRST != 0 && same_addr) begin
        rd_word = bus.in;
      end else begin
        rd_word = mem[bus.read_addr0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && bus.write_en && wr_in_range) begin
      mem[bus.write_addr0] <= bus.in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      write_done_reg <= 1'b0;
    end else begin
      write_done_reg <= bus.write_en;
    end
  end

  // Read pipeline: data advances with its valid bit; the last stage is the visible out register.
  for (genvar gi = 0; gi < READ_LATENCY; gi++) begin : g_stage
    logic             valid_reg;
    logic [WIDTH-1:0] data_reg;
    logic             valid_next;
    logic [WIDTH-1:0] data_next;

    if (gi == 0) begin : g_head
      assign valid_next = bus.read_en;
      assign data_next  = rd_word;
    end else begin : g_body
      assign valid_next = g_stage[gi-1].valid_reg;
      assign data_next  = g_stage[gi-1].data_reg;
    end

    if (gi == READ_LATENCY - 1) begin : g_last
      always_ff @(posedge clk) begin
        if (reset) begin
          valid_reg <= 1'b0;
          data_reg  <= '0;
        end else begin
          valid_reg <= valid_next;
          if (valid_next) begin
            data_reg <= data_next;
          end
        end
      end
    end else begin : g_mid
      always_ff @(posedge clk) begin
        if (reset) begin
          valid_reg <= 1'b0;
        end else begin
          valid_reg <= valid_next;
        end
      end

      always_ff @(posedge clk) begin
        if (valid_next) begin
          data_reg <= data_next;
        end
      end
    end
  end

  assign bus.out        = g_stage[READ_LATENCY-1].data_reg;
  assign bus.read_done  = g_stage[READ_LATENCY-1].valid_reg;
  assign bus.write_done = write_done_reg;

  always_ff @(posedge clk) begin
    if (!reset && OOB_ERROR != 0) begin
      if (bus.write_en && !wr_in_range) begin
        $error("seq_mem_d1_2p: write address %0d out of range", bus.write_addr0);
      end
      if (bus.read_en && !rd_in_range) begin
        $error("seq_mem_d1_2p: read address %0d out of range", bus.read_addr0);
      end
    end
  end

endmodule

// File: tb/tb_seq_mem_d1_2p.sv
// Bench for seq_mem_d1_2p: four configurations share one stimulus stream; a directed table
// and hand sequences check fixed values, a slot-based scoreboard checks every cycle.
module tb_seq_mem_d1_2p;

  localparam int NI = 4;

  function automatic int cfg_lat(input int i);
    case (i)
      0:       return 1;
      1:       return 3;
      2:       return 4;
      default: return 2;
    endcase
  endfunction

  function automatic int cfg_wf(input int i);
    return (i == 0 || i == 3) ? 1 : 0;
  endfunction

  function automatic int cfg_size(input int i);
    return (i == 1) ? 12 : 16;
  endfunction

  bit          clk = 1'b1;
  logic        rst;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;

  logic [NI-1:0] rd_done_w;
  logic [NI-1:0] wr_done_w;
  logic [31:0]   out_w [NI];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    localparam int L  = cfg_lat(gi);
    localparam int WF = cfg_wf(gi);
    localparam int S  = cfg_size(gi);

    seq_mem_d1_2p_if #(.WIDTH(32), .IDX_SIZE(4)) bus_i ();

    assign bus_i.read_addr0  = rd_addr;
    assign bus_i.read_en     = rd_en;
    assign bus_i.write_addr0 = wr_addr;
    assign bus_i.in          = wr_data;
    assign bus_i.write_en    = wr_en;
    assign rd_done_w[gi]     = bus_i.read_done;
    assign wr_done_w[gi]     = bus_i.write_done;
    assign out_w[gi]         = bus_i.out;

    seq_mem_d1_2p #(
      .WIDTH(32), .SIZE(S), .IDX_SIZE(4), .READ_LATENCY(L),
      .WRITE_FIRST(WF), .OOB_ERROR((S == 16) ? 1 : 0)
    ) dut (
      .clk  (clk),
      .reset(rst),
      .bus  (bus_i.slave)
    );

    // Scoreboard: a read issued in cycle c is expected to complete in slot (c+L).
    logic [31:0] m_mem   [16];
    bit          m_known [16];
    bit          s_valid [8];
    bit          s_known [8];
    bit          s_rst   [8];
    logic [31:0] s_data  [8];
    logic [31:0] exp_out   = '0;
    bit          out_known = 1'b0;
    bit          exp_wd    = 1'b0;
    bit          armed     = 1'b0;
    int          cyc       = 0;

    always @(negedge clk) begin
      int          s;
      logic [31:0] rdat;
      bit          rk;
      s = cyc % 8;
      if (s_rst[s]) begin
        exp_out   = '0;
        out_known = 1'b1;
      end
      if (s_valid[s]) begin
        exp_out   = s_data[s];
        out_known = s_known[s];
      end
      if (armed) begin
        chk($sformatf("model%0d c%0d read_done", gi, cyc), {31'b0, rd_done_w[gi]}, {31'b0, s_valid[s]});
        chk($sformatf("model%0d c%0d write_done", gi, cyc), {31'b0, wr_done_w[gi]}, {31'b0, exp_wd});
        if (out_known) begin
          chk($sformatf("model%0d c%0d out", gi, cyc), out_w[gi], exp_out);
        end
      end
      s_valid[s] = 1'b0;
      s_rst[s]   = 1'b0;
      if (rst) begin
        armed = 1'b1;
        for (int k = 0; k < 8; k++) s_valid[k] = 1'b0;
        s_rst[(cyc + 1) % 8] = 1'b1;
        exp_wd = 1'b0;
      end else begin
        exp_wd = wr_en;
        if (rd_en) begin
          if (int'(rd_addr) >= S) begin
            rdat = '0;
            rk   = 1'b1;
          end else if (WF != 0 && wr_en && wr_addr == rd_addr) begin
            rdat = wr_data;
            rk   = 1'b1;
          end else begin
            rdat = m_mem[rd_addr];
            rk   = m_known[rd_addr];
          end
          s_valid[(cyc + L) % 8] = 1'b1;
          s_data[(cyc + L) % 8]  = rdat;
          s_known[(cyc + L) % 8] = rk;
        end
        if (wr_en && int'(wr_addr) < S) begin
          m_mem[wr_addr]   = wr_data;
          m_known[wr_addr] = 1'b1;
        end
      end
      cyc++;
    end
  end

  typedef struct {
    bit          rst;
    bit          re;
    logic [3:0]  ra;
    bit          we;
    logic [3:0]  wa;
    logic [31:0] wd;
    bit          e_rd;
    bit          e_wd;
    logic [31:0] e_out;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(input bit r, input bit re, input int ra, input bit we, input int wa,
                              input int wd, input bit e_rd, input bit e_wd, input int e_out);
    vec_t v;
    v.rst = r; v.re = re; v.ra = 4'(ra); v.we = we; v.wa = 4'(wa); v.wd = 32'(wd);
    v.e_rd = e_rd; v.e_wd = e_wd; v.e_out = 32'(e_out);
    return v;
  endfunction

  task automatic step(input bit r, input bit re, input int ra, input bit we, input int wa, input int wd);
    rst     = r;
    rd_en   = re;
    rd_addr = 4'(ra);
    wr_en   = we;
    wr_addr = 4'(wa);
    wr_data = 32'(wd);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Directed vectors observed on instance 0 (latency 1, write-first, 16 words).
    tbl[0]  = mk(1, 0, 0, 0, 0, 0,     0, 0, 0);
    for (int i = 1; i <= 5; i++) tbl[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0, 1, 3, 'hA5, 0, 1, 0);
    tbl[7]  = mk(0, 1, 3, 0, 0, 0,     1, 0, 'hA5);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0,     0, 0, 'hA5);
    tbl[9]  = mk(0, 0, 0, 1, 5, 'h11, 0, 1, 'hA5);
    tbl[10] = mk(0, 1, 5, 1, 5, 'h55, 1, 1, 'h55);
    tbl[11] = mk(0, 1, 5, 0, 0, 0,     1, 0, 'h55);
    tbl[12] = mk(0, 1, 3, 1, 6, 'h66, 1, 1, 'hA5);
    tbl[13] = mk(0, 1, 6, 0, 0, 0,     1, 0, 'h66);
    tbl[14] = mk(0, 0, 0, 1, 6, 'h99, 0, 1, 'h66);
    tbl[15] = mk(1, 1, 6, 1, 3, 'h12, 0, 0, 0);
    tbl[16] = mk(0, 1, 3, 0, 0, 0,     1, 0, 'hA5);

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].rst, tbl[i].re, int'(tbl[i].ra), tbl[i].we, int'(tbl[i].wa), int'(tbl[i].wd));
      chk($sformatf("vec%0d read_done", i), {31'b0, rd_done_w[0]}, {31'b0, tbl[i].e_rd});
      chk($sformatf("vec%0d write_done", i), {31'b0, wr_done_w[0]}, {31'b0, tbl[i].e_wd});
      chk($sformatf("vec%0d out", i), out_w[0], tbl[i].e_out);
      $display("vec %0d: read_done=%0b write_done=%0b out=%h", i, rd_done_w[0], wr_done_w[0], out_w[0]);
    end

    // Back-to-back reads through a 3-deep pipeline (instance 1).
    step(0, 0, 0, 1, 0, 10);
    step(0, 0, 0, 1, 1, 11);
    step(0, 0, 0, 1, 2, 12);
    idle();
    step(0, 1, 0, 0, 0, 0);
    chk("lat3 early0", {31'b0, rd_done_w[1]}, 32'd0);
    step(0, 1, 1, 0, 0, 0);
    chk("lat3 early1", {31'b0, rd_done_w[1]}, 32'd0);
    step(0, 1, 2, 0, 0, 0);
    chk("lat3 done0", {31'b0, rd_done_w[1]}, 32'd1);
    chk("lat3 out0", out_w[1], 32'd10);
    idle();
    chk("lat3 done1", {31'b0, rd_done_w[1]}, 32'd1);
    chk("lat3 out1", out_w[1], 32'd11);
    idle();
    chk("lat3 done2", {31'b0, rd_done_w[1]}, 32'd1);
    chk("lat3 out2", out_w[1], 32'd12);
    idle();
    chk("lat3 idle", {31'b0, rd_done_w[1]}, 32'd0);
    chk("lat3 hold", out_w[1], 32'd12);
    $display("seq lat3: out=%h", out_w[1]);

    // Read-first collision (instances 1 and 2), then the new word is visible.
    step(0, 0, 0, 1, 5, 'h11);
    step(0, 1, 5, 1, 5, 'h55);
    idle();
    idle();
    chk("rf lat3 done", {31'b0, rd_done_w[1]}, 32'd1);
    chk("rf lat3 out", out_w[1], 32'h11);
    idle();
    chk("rf lat4 done", {31'b0, rd_done_w[2]}, 32'd1);
    chk("rf lat4 out", out_w[2], 32'h11);
    step(0, 1, 5, 0, 0, 0);
    idle();
    idle();
    chk("rf after", out_w[1], 32'h55);
    $display("seq collision: old=%h new=%h", out_w[2], out_w[1]);

    // Reset while a latency-2 read is in flight (instance 3).
    step(0, 0, 0, 1, 7, 'h77);
    step(0, 1, 7, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("rst drop done", {31'b0, rd_done_w[3]}, 32'd0);
    chk("rst drop out", out_w[3], 32'd0);
    idle();
    chk("rst drop late", {31'b0, rd_done_w[3]}, 32'd0);
    step(0, 1, 7, 0, 0, 0);
    idle();
    chk("rst reread done", {31'b0, rd_done_w[3]}, 32'd1);
    chk("rst reread out", out_w[3], 32'h77);
    $display("seq reset: out=%h", out_w[3]);

    // Out-of-range access on the 12-word instance.
    step(0, 0, 0, 1, 1, 'h3C);
    step(0, 0, 0, 1, 13, 'hEE);
    chk("oob write_done", {31'b0, wr_done_w[1]}, 32'd1);
    step(0, 1, 13, 0, 0, 0);
    idle();
    idle();
    chk("oob read done", {31'b0, rd_done_w[1]}, 32'd1);
    chk("oob read out", out_w[1], 32'd0);
    step(0, 1, 1, 0, 0, 0);
    idle();
    idle();
    chk("oob no alias", out_w[1], 32'h3C);
    $display("seq oob: out=%h", out_w[1]);

    // Randomised traffic; the scoreboards check every instance each cycle.
    step(1, 0, 0, 0, 0, 0);
    for (int a = 0; a < 16; a++) step(0, 0, 0, 1, a, int'($urandom));
    for (int n = 0; n < 2000; n++) begin
      step(($urandom_range(63) == 0) ? 1'b1 : 1'b0, 1'($urandom), int'($urandom_range(15)),
           1'($urandom), int'($urandom_range(15)), int'($urandom));
    end
    for (int n = 0; n < 6; n++) idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
